transmission8_driver: RTL

- Clocked sequencer directly upstream of the 8-bit transmission stage.
- Accepts a data byte and a 3-bit control code over a valid/ready handshake, then drives the stage's data bus and its A/B/C controls in a fixed setup/active/hold sequence.
- Samples the stage's returned 8-bit output at the end of the active window and reports it with a done pulse.
- Replaces hand-timed A/B/C stimulus with a reusable, cycle-exact driver.

---
 rtl/transmission8_pkg.sv | 17 +
 rtl/transmission8_dwell_cnt.sv | 37 +++
 rtl/transmission8_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/transmission8_pkg.sv
// Shared types and constants for the transmission8 driver: FSM state encoding,
// control-code constants and the default data width.
package transmission8_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StActive = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_ALL  = 3'b111;

  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/transmission8_dwell_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag
// that is high while the count equals Max.
module transmission8_dwell_cnt #(
  parameter int unsigned Width = 8,
  parameter int unsigned Max   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == Width'(Max));

endmodule

// File: rtl/transmission8_driver.sv
// Setup/active/hold sequencer for the 8-bit transmission stage with return capture.
// Define TRANSMISSION8_DRIVER_SWEEP_EN to step through all eight codes in ACTIVE.
module transmission8_driver
  import transmission8_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DWELL  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iByte,
  input  logic [2:0]        iCode,
  output logic [DATA_W-1:0] oData,
  output logic              oA,
  output logic              oB,
  output logic              oC,
  input  logic [DATA_W-1:0] iRet,
  output logic [DATA_W-1:0] oCapt,
  output logic              oDone
);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] capt_d, capt_q;
  logic [2:0]        abc_d, abc_q;
  logic              done_d, done_q;

  logic              cnt_clr, cnt_en, dwell_tc;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              unused_dwell_cnt;

  assign unused_dwell_cnt = ^dwell_cnt;

  transmission8_dwell_cnt #(
    .Width (CNT_W),
    .Max   (DWELL - 1)
  ) u_dwell_cnt (
    .clk_i (iClk),
    .rst_i (iRst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (dwell_cnt),
    .tc_o  (dwell_tc)
  );

`ifdef TRANSMISSION8_DRIVER_SWEEP_EN
  logic       idx_clr, idx_en, idx_tc;
  logic [2:0] idx_cnt;
  logic       unused_code;

  assign unused_code = ^iCode;

  // Sweep index doubles as the control code driven in the current sub-window.
  transmission8_dwell_cnt #(
    .Width (3),
    .Max   (int'(CODE_ALL))
  ) u_idx_cnt (
    .clk_i (iClk),
    .rst_i (iRst),
    .clr_i (idx_clr),
    .en_i  (idx_en),
    .cnt_o (idx_cnt),
    .tc_o  (idx_tc)
  );
`else
  logic [2:0] code_d, code_q;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    capt_d  = capt_q;
    abc_d   = abc_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef TRANSMISSION8_DRIVER_SWEEP_EN
    idx_clr = 1'b0;
    idx_en  = 1'b0;
`else
    code_d  = code_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
`ifdef TRANSMISSION8_DRIVER_SWEEP_EN
        idx_clr = 1'b1;
`endif
        if (iValid) begin
          data_d  = iByte;
`ifndef TRANSMISSION8_DRIVER_SWEEP_EN
          code_d  = iCode;
`endif
          abc_d   = CODE_NONE;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_clr = 1'b1;
`ifdef TRANSMISSION8_DRIVER_SWEEP_EN
        abc_d   = CODE_NONE;
`else
        abc_d   = code_q;
`endif
        state_d = StActive;
      end
      StActive: begin
        cnt_en = 1'b1;
        if (dwell_tc) begin
          // Capture at the edge that closes the (sub-)window while iRet reflects it.
          capt_d  = iRet;
          done_d  = 1'b1;
          cnt_clr = 1'b1;
`ifdef TRANSMISSION8_DRIVER_SWEEP_EN
          if (idx_tc) begin
            abc_d   = CODE_NONE;
            state_d = StHold;
          end else begin
            idx_en = 1'b1;
            abc_d  = idx_cnt + 3'd1;
          end
`else
          abc_d   = CODE_NONE;
          state_d = StHold;
`endif
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= StIdle;
      data_q  <= '0;
      capt_q  <= '0;
      abc_q   <= CODE_NONE;
      done_q  <= 1'b0;
`ifndef TRANSMISSION8_DRIVER_SWEEP_EN
      code_q  <= CODE_NONE;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      capt_q  <= capt_d;
      abc_q   <= abc_d;
      done_q  <= done_d;
`ifndef TRANSMISSION8_DRIVER_SWEEP_EN
      code_q  <= code_d;
`endif
    end
  end

  assign oReady         = (state_q == StIdle);
  assign oData          = data_q;
  assign {oA, oB, oC}   = abc_q;
  assign oCapt          = capt_q;
  assign oDone          = done_q;

endmodule
